// File: rtl/sobel_window_sequencer.sv
// Raster pixel stream to 3x3 neighbourhood sequencer feeding gradient_calculation.
// Optional win_count output is enabled by defining SOBEL_WIN_COUNT_EN.
module sobel_window_sequencer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        frame_start,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic        pixel_in_ready,
    output logic [71:0] window_out,
    output logic        window_out_valid,
    output logic        busy,
    output logic        frame_done
`ifdef SOBEL_WIN_COUNT_EN
    ,
    output logic [19:0] win_count
`endif
);

    localparam int DATA_W = 8;
    localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t state, next_state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last, row_last;
    logic          acc_p0, vld_p0;

    logic [DATA_W-1:0] lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] tap_p0  [3];
    logic [DATA_W-1:0] hist_p0 [3][2];
    logic [71:0]       win_nxt;

    always_comb begin
        pixel_in_ready = ((state == FILL) || (state == STREAM)) && !frame_start;
        acc_p0         = pixel_in_valid && pixel_in_ready;
        col_last       = (col == CW'(IMG_WIDTH - 1));
        row_last       = (row == RW'(IMG_HEIGHT - 1));
        vld_p0         = acc_p0 && (state == STREAM) && (col >= CW'(2));
    end

    always_comb begin
        next_state = state;
        if (frame_start) begin
            next_state = FILL;
        end else begin
            case (state)
                FILL:    if (acc_p0 && (row == RW'(1)) && col_last) next_state = STREAM;
                STREAM:  if (acc_p0 && row_last && col_last) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Stage p0: column taps from the line buffers, window assembled from history
    always_comb begin
        tap_p0[0] = lb1[col];
        tap_p0[1] = lb0[col];
        tap_p0[2] = pixel_in;
        win_nxt   = '0;
        for (int k = 0; k < 3; k++) begin
            win_nxt[(3*k+0)*8 +: 8] = hist_p0[k][0];
            win_nxt[(3*k+1)*8 +: 8] = hist_p0[k][1];
            win_nxt[(3*k+2)*8 +: 8] = tap_p0[k];
        end
    end

    always_ff @(posedge clk) begin
        if (acc_p0) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pixel_in;
            for (int k = 0; k < 3; k++) begin
                hist_p0[k][0] <= hist_p0[k][1];
                hist_p0[k][1] <= tap_p0[k];
            end
        end
    end

    // Stage p1: registered window output, counters and frame control
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state            <= IDLE;
            row              <= '0;
            col              <= '0;
            window_out       <= '0;
            window_out_valid <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            state            <= next_state;
            window_out_valid <= vld_p0;
            frame_done       <= (state == DONE) && !frame_start;
            if (vld_p0) window_out <= win_nxt;
            if (frame_start) begin
                row <= '0;
                col <= '0;
            end else if (acc_p0) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

`ifdef SOBEL_WIN_COUNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)            win_count <= '0;
        else if (frame_start) win_count <= '0;
        else if (vld_p0)      win_count <= win_count + 20'd1;
    end
`endif

    assign busy = (state == FILL) || (state == STREAM);

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Scoreboard bench for sobel_window_sequencer on a 4x4 frame (5x4 count test with SOBEL_WIN_COUNT_EN).
module tb_sobel_window_sequencer;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        frame_start;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic [71:0] window_out;
    logic        window_out_valid;
    logic        busy;
    logic        frame_done;
`ifdef SOBEL_WIN_COUNT_EN
    logic [19:0] win_count;
`endif

    sobel_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rstN(rstN), .frame_start(frame_start),
        .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_ready(pixel_in_ready),
        .window_out(window_out), .window_out_valid(window_out_valid),
        .busy(busy), .frame_done(frame_done)
`ifdef SOBEL_WIN_COUNT_EN
        , .win_count(win_count)
`endif
    );

`ifdef SOBEL_WIN_COUNT_EN
    logic        c_fs, c_valid, c_ready, c_wvalid, c_busy, c_done;
    logic [7:0]  c_pix;
    logic [71:0] c_wout;
    logic [19:0] c_count;

    sobel_window_sequencer #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) u_cnt (
        .clk(clk), .rstN(rstN), .frame_start(c_fs),
        .pixel_in(c_pix), .pixel_in_valid(c_valid), .pixel_in_ready(c_ready),
        .window_out(c_wout), .window_out_valid(c_wvalid),
        .busy(c_busy), .frame_done(c_done), .win_count(c_count)
    );
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [71:0] win;
        int          due;
    } exp_t;

    typedef struct {
        bit         fs;
        bit         v;
        logic [7:0] pix;
        bit         exp_ready;
        bit         exp_busy;
    } vec_t;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [71:0] got[$];
    int          fd_count = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 9; i++)
            w[i*8 +: 8] = 8'((r - 2 + i / 3) * 16 + (c - 2 + i % 3));
        return w;
    endfunction

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (window_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("window_valid_without_accept", window_out_valid, 0);
            end else begin
                e_mon = sb.pop_front();
                check("window_data", window_out, e_mon.win);
                check("window_latency", cyc, e_mon.due);
                got.push_back(window_out);
            end
        end
    end

    // Drive one pixel cycle; returns 1 ns after the clock edge that samples it.
    task automatic send(input bit v, input int r, input int c, input bit active);
        pixel_in       = 8'(r * 16 + c);
        pixel_in_valid = v;
        if (v && active && r >= 2 && c >= 2) sb.push_back('{exp_win(r, c), cyc + 1});
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
    endtask

    task automatic pulse_fs(input bit with_pix);
        frame_start    = 1'b1;
        pixel_in_valid = with_pix;
        pixel_in       = 8'hAA;
        @(negedge clk);
        check("ready_low_on_frame_start", pixel_in_ready, 0);
        @(posedge clk);
        #1;
        frame_start    = 1'b0;
        pixel_in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(1'b1, r, c, 1'b1);
                if (gaps) send(1'b0, 0, 0, 1'b1);
            end
        if (!gaps) begin
            @(negedge clk);
            check("frame_done_early", frame_done, 0);
        end
        @(negedge clk);
        check("frame_done_pulse", frame_done, 1);
        check("busy_after_done", busy, 0);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        check("frame_done_single", frame_done, 0);
    endtask

    vec_t vecs[7];
    int   base;
    int   fdc;

    initial begin
        vecs[0] = '{0, 1, 8'h11, 0, 0};
        vecs[1] = '{0, 1, 8'h12, 0, 0};
        vecs[2] = '{0, 1, 8'h13, 0, 0};
        vecs[3] = '{1, 1, 8'h14, 0, 0};
        vecs[4] = '{0, 0, 8'h15, 1, 1};
        vecs[5] = '{1, 1, 8'h16, 0, 1};
        vecs[6] = '{0, 0, 8'h17, 1, 1};

        rstN = 1'b0; frame_start = 1'b0; pixel_in = '0; pixel_in_valid = 1'b0;
`ifdef SOBEL_WIN_COUNT_EN
        c_fs = 1'b0; c_valid = 1'b0; c_pix = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_window_out", window_out, 0);
        check("reset_window_valid", window_out_valid, 0);
        check("reset_ready", pixel_in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Idle pixels, frame_start with a pixel in IDLE, and an abort in FILL.
        for (int i = 0; i < 7; i++) begin
            frame_start    = vecs[i].fs;
            pixel_in_valid = vecs[i].v;
            pixel_in       = vecs[i].pix;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), pixel_in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            @(posedge clk);
            #1;
        end
        frame_start = 1'b0;

        base = got.size();
        run_frame(1'b0);
        check("frame1_window_count", got.size() - base, 4);
        if (got.size() >= 4) begin
            check("first_window", got[0], 72'h222120121110020100);
            check("last_window", got[3], 72'h333231232221131211);
        end
`ifdef SOBEL_WIN_COUNT_EN
        check("win_count_frame1", win_count, 4);
`endif

        pulse_fs(1'b0);
        base = got.size();
        run_frame(1'b1);
        check("gapped_window_count", got.size() - base, 4);
        if (got.size() - base == 4)
            for (int i = 0; i < 4; i++) check("gapped_matches_first", got[base + i], got[i]);

        for (int i = 0; i < 3; i++) begin
            pixel_in_valid = 1'b1;
            pixel_in       = 8'(8'h40 + i);
            @(negedge clk);
            check("idle_ready", pixel_in_ready, 0);
            check("idle_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        pixel_in_valid = 1'b0;

        pulse_fs(1'b0);
        for (int p = 0; p < 9; p++) send(1'b1, p / W, p % W, 1'b1);
        fdc = fd_count;
        pulse_fs(1'b1);
        base = got.size();
        run_frame(1'b0);
        check("restart_frame_done_count", fd_count, fdc + 1);
        check("restart_window_count", got.size() - base, 4);
        if (got.size() - base == 4)
            for (int i = 0; i < 4; i++) check("restart_matches_first", got[base + i], got[i]);

        pulse_fs(1'b0);
        for (int p = 0; p < 11; p++) send(1'b1, p / W, p % W, 1'b1);
        #1;
        check("pre_reset_valid", window_out_valid, 1);
        rstN = 1'b0;
        sb.delete();
        #1;
        check("async_reset_window_out", window_out, 0);
        check("async_reset_valid", window_out_valid, 0);
        check("async_reset_ready", pixel_in_ready, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_frame_done", frame_done, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        pulse_fs(1'b0);
        base = got.size();
        run_frame(1'b0);
        check("post_reset_window_count", got.size() - base, 4);
        if (got.size() - base == 4)
            for (int i = 0; i < 4; i++) check("post_reset_matches_first", got[base + i], got[i]);

`ifdef SOBEL_WIN_COUNT_EN
        begin
            int nwin;
            int t;
            nwin = 0;
            c_fs = 1'b1;
            @(posedge clk);
            #1;
            c_fs = 1'b0;
            for (int p = 0; p < 20; p++) begin
                c_valid = 1'b1;
                c_pix   = 8'((p / 5) * 16 + (p % 5));
                @(negedge clk);
                if (c_wvalid) nwin++;
                @(posedge clk);
                #1;
            end
            c_valid = 1'b0;
            t = 0;
            @(negedge clk);
            while (c_done !== 1'b1 && t < 10) begin
                if (c_wvalid) nwin++;
                t++;
                @(negedge clk);
            end
            check("count_frame_done_seen", c_done, 1);
            check("count_win_count", c_count, 6);
            check("count_windows_seen", nwin, 6);
            check("count_last_window", c_wout, 72'h343332242322141312);
            check("count_busy", c_busy, 0);
            check("count_ready_idle", c_ready, 0);
            repeat (2) @(negedge clk);
            check("count_hold", c_count, 6);
            c_fs = 1'b1;
            @(posedge clk);
            #1;
            c_fs = 1'b0;
            check("count_cleared", c_count, 0);
        end
`endif

        repeat (3) @(posedge clk);
        check("final_scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
